// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C transaction arbiter.
package i2c_arb_pkg;

   localparam int unsigned I2C_ADDR_W = 8;
   localparam int unsigned I2C_DATA_W = 24;
   localparam int unsigned I2C_WDOG_W = 16;

   // Legacy state encodings, kept so existing decode logic elsewhere still matches.
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_LAUNCH    = 2'd1;
   localparam logic [1:0] ST_WAIT_STOP = 2'd2;
   localparam logic [1:0] ST_RESPOND   = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = ST_IDLE,
      LAUNCH    = ST_LAUNCH,
      WAIT_STOP = ST_WAIT_STOP,
      RESPOND   = ST_RESPOND
   } i2c_arb_state_t;

endpackage

// File: rtl/i2c_rr_picker.sv
// Round-robin search: first pending request at or above rr_ptr, wrapping.
module i2c_rr_picker
   import i2c_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic               any,
   output logic [PTR_W-1:0]   owner
);

   int unsigned idx;

   always_comb begin
      any   = 1'b0;
      owner = '0;
      idx   = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(rr_ptr) + i) % NUM_REQ;
         if (!any && req_valid[idx]) begin
            any   = 1'b1;
            owner = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C controller between NUM_REQ requesters, one whole transaction at a time,
// tracking completion from START/STOP on the controller's scl/sda_out.
module i2c_txn_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*I2C_ADDR_W-1:0]    req_addr,
   input  logic [NUM_REQ*I2C_DATA_W-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               req_grant,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [I2C_DATA_W-1:0]            rsp_rdata,
   output logic                             rsp_nack,
   output logic                             rsp_timeout,
   output logic                             busy,
   output logic                             i2c_start,
   output logic [I2C_ADDR_W-1:0]            i2c_addr,
   output logic [I2C_DATA_W-1:0]            i2c_data_snt,
   input  logic                             i2c_scl,
   input  logic                             i2c_sda_out,
   input  logic                             i2c_ack,
   input  logic [I2C_DATA_W-1:0]            i2c_data_rcv
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [I2C_WDOG_W-1:0] WDOG_LAST = I2C_WDOG_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(NUM_REQ - 1);

   i2c_arb_state_t         state;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       owner_q;
   logic [I2C_WDOG_W-1:0]  wdog;
   logic                   sda_q;
   logic                   scl_q;

   logic                   pick_any;
   logic [PTR_W-1:0]       pick_idx;
   logic                   start_det;
   logic                   stop_det;
   logic                   wdog_exp;
   logic                   done_ok;
   logic                   done_to;

   i2c_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .any       (pick_any),
      .owner     (pick_idx)
   );

   always_comb begin
      start_det = sda_q & ~i2c_sda_out & scl_q & i2c_scl;
      stop_det  = ~sda_q & i2c_sda_out & scl_q & i2c_scl;
      wdog_exp  = (wdog == WDOG_LAST);
      done_ok   = (state == WAIT_STOP) && stop_det;
      // A bus event seen in the final watchdog cycle takes priority over expiry.
      done_to   = wdog_exp && !done_ok &&
                  ((state == WAIT_STOP) || ((state == LAUNCH) && !start_det));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         owner_q      <= '0;
         wdog         <= '0;
         sda_q        <= 1'b1;
         scl_q        <= 1'b1;
         req_grant    <= '0;
         rsp_valid    <= '0;
         rsp_rdata    <= '0;
         rsp_nack     <= 1'b0;
         rsp_timeout  <= 1'b0;
         busy         <= 1'b0;
         i2c_start    <= 1'b0;
         i2c_addr     <= '0;
         i2c_data_snt <= '0;
      end else begin
         sda_q     <= i2c_sda_out;
         scl_q     <= i2c_scl;
         req_grant <= '0;
         rsp_valid <= '0;

         if (done_ok || done_to) begin
            state       <= RESPOND;
            i2c_start   <= 1'b0;
            rsp_valid   <= NUM_REQ'(1) << owner_q;
            rsp_timeout <= done_to;
            rsp_nack    <= done_ok & i2c_ack;
            rsp_rdata   <= (done_ok && i2c_addr[0]) ? i2c_data_rcv : '0;
         end else begin
            case (state)
               IDLE: begin
                  if (pick_any) begin
                     owner_q      <= pick_idx;
                     i2c_addr     <= req_addr[pick_idx*I2C_ADDR_W +: I2C_ADDR_W];
                     i2c_data_snt <= req_wdata[pick_idx*I2C_DATA_W +: I2C_DATA_W];
                     rr_ptr       <= (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
                     wdog         <= '0;
                     req_grant    <= NUM_REQ'(1) << pick_idx;
                     i2c_start    <= 1'b1;
                     busy         <= 1'b1;
                     state        <= LAUNCH;
                  end
               end
               LAUNCH: begin
                  wdog <= wdog + 1'b1;
                  if (start_det) begin
                     i2c_start <= 1'b0;
                     state     <= WAIT_STOP;
                  end
               end
               WAIT_STOP: begin
                  wdog <= wdog + 1'b1;
               end
               RESPOND: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter; the bench plays the I2C controller's bus side.
module tb_i2c_txn_arbiter;

   localparam int unsigned NREQ = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*8-1:0] req_addr;
   logic [NREQ*24-1:0] req_wdata;
   logic [NREQ-1:0]   req_grant;
   logic [NREQ-1:0]   rsp_valid;
   logic [23:0]       rsp_rdata;
   logic              rsp_nack;
   logic              rsp_timeout;
   logic              busy;
   logic              i2c_start;
   logic [7:0]        i2c_addr;
   logic [23:0]       i2c_data_snt;
   logic              scl;
   logic              sda;
   logic              ack;
   logic [23:0]       rcv;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   int unsigned cyc;

   always #5 clk = ~clk;

   i2c_txn_arbiter #(
      .NUM_REQ        (NREQ),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_grant    (req_grant),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_nack     (rsp_nack),
      .rsp_timeout  (rsp_timeout),
      .busy         (busy),
      .i2c_start    (i2c_start),
      .i2c_addr     (i2c_addr),
      .i2c_data_snt (i2c_data_snt),
      .i2c_scl      (scl),
      .i2c_sda_out  (sda),
      .i2c_ack      (ack),
      .i2c_data_rcv (rcv)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input int unsigned idx, input logic [7:0] a, input logic [23:0] d);
      req_addr[idx*8 +: 8]    = a;
      req_wdata[idx*24 +: 24] = d;
   endtask

   task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp, output int unsigned n);
      n = 0;
      do begin
         tick();
         n++;
      end while (req_grant == '0 && n < 40);
      chk(tag, 32'(req_grant), 32'(exp));
   endtask

   task automatic wait_rsp(input string tag, input logic [NREQ-1:0] exp, output int unsigned n);
      n = 0;
      do begin
         tick();
         n++;
      end while (rsp_valid == '0 && n < 80);
      chk(tag, 32'(rsp_valid), 32'(exp));
   endtask

   // START on the next edge, then scl low for two cycles of "data".
   task automatic bus_start();
      sda = 1'b0;
      tick();
      scl = 1'b0;
      tick();
      tick();
   endtask

   // scl high with sda low, then sda rises: STOP detected at the edge after the
   // second step; returns one negedge later, in the rsp_valid cycle.
   task automatic bus_stop(input logic a, input logic [23:0] d);
      ack = a;
      rcv = d;
      sda = 1'b0;
      scl = 1'b1;
      tick();
      sda = 1'b1;
      tick();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_grant"},   32'(req_grant),    32'h0);
      chk({tag, "_rspv"},    32'(rsp_valid),    32'h0);
      chk({tag, "_rdata"},   32'(rsp_rdata),    32'h0);
      chk({tag, "_nack"},    32'(rsp_nack),     32'h0);
      chk({tag, "_tmo"},     32'(rsp_timeout),  32'h0);
      chk({tag, "_busy"},    32'(busy),         32'h0);
      chk({tag, "_start"},   32'(i2c_start),    32'h0);
      chk({tag, "_addr"},    32'(i2c_addr),     32'h0);
      chk({tag, "_data"},    32'(i2c_data_snt), 32'h0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_addr  = '0;
      req_wdata = '0;
      scl       = 1'b1;
      sda       = 1'b1;
      ack       = 1'b0;
      rcv       = '0;
      repeat (3) tick();
      chk_reset_outputs("rst0");

      // Single write, requester 2
      rst = 1'b0;
      set_req(2, 8'h90, 24'hA5C33C);
      req_valid = 4'b0100;
      wait_grant("wr_grant", 4'b0100, cyc);
      chk("wr_grant_lat", cyc, 1);
      chk("wr_start", 32'(i2c_start), 1);
      chk("wr_busy", 32'(busy), 1);
      chk("wr_addr", 32'(i2c_addr), 32'h90);
      chk("wr_data", 32'(i2c_data_snt), 32'hA5C33C);
      req_valid = '0;
      bus_start();
      chk("wr_start_drop", 32'(i2c_start), 0);
      bus_stop(1'b0, 24'hFFFFFF);
      chk("wr_rspv", 32'(rsp_valid), 32'b0100);
      chk("wr_rdata", 32'(rsp_rdata), 0);
      chk("wr_nack", 32'(rsp_nack), 0);
      chk("wr_tmo", 32'(rsp_timeout), 0);
      tick();
      chk("wr_rspv_pulse", 32'(rsp_valid), 0);
      chk("wr_idle_busy", 32'(busy), 0);
      chk("wr_addr_hold", 32'(i2c_addr), 32'h90);

      // Read, requester 0
      set_req(0, 8'h91, 24'h0);
      req_valid = 4'b0001;
      wait_grant("rd_grant", 4'b0001, cyc);
      req_valid = '0;
      bus_start();
      bus_stop(1'b0, 24'h123456);
      chk("rd_rspv", 32'(rsp_valid), 32'b0001);
      chk("rd_rdata", 32'(rsp_rdata), 32'h123456);
      chk("rd_nack", 32'(rsp_nack), 0);
      tick();

      // NACK on a read, requester 1
      set_req(1, 8'h41, 24'h0);
      req_valid = 4'b0010;
      wait_grant("nk_grant", 4'b0010, cyc);
      req_valid = '0;
      bus_start();
      bus_stop(1'b1, 24'hABCDEF);
      chk("nk_rspv", 32'(rsp_valid), 32'b0010);
      chk("nk_nack", 32'(rsp_nack), 1);
      chk("nk_tmo", 32'(rsp_timeout), 0);
      chk("nk_rdata", 32'(rsp_rdata), 32'hABCDEF);
      tick();

      // Watchdog expiry with bus idle, requester 3
      set_req(3, 8'h23, 24'h111111);
      req_valid = 4'b1000;
      wait_grant("to_grant", 4'b1000, cyc);
      req_valid = '0;
      wait_rsp("to_rspv", 4'b1000, cyc);
      chk("to_latency", cyc, 50);
      chk("to_tmo", 32'(rsp_timeout), 1);
      chk("to_nack", 32'(rsp_nack), 0);
      chk("to_rdata", 32'(rsp_rdata), 0);
      tick();

      // STOP in the last watchdog cycle beats expiry, requester 0 (rr_ptr wrapped to 0)
      set_req(0, 8'h32, 24'h0);
      req_valid = 4'b0001;
      wait_grant("race_grant", 4'b0001, cyc);
      req_valid = '0;
      ack = 1'b1;
      for (int unsigned c = 1; c <= 50; c++) begin
         if (c == 1)       sda = 1'b0;
         else if (c == 2)  scl = 1'b0;
         else if (c == 49) scl = 1'b1;
         else if (c == 50) sda = 1'b1;
         if (c < 50) begin
            chk("race_early", 32'(rsp_valid), 0);
         end
         tick();
      end
      chk("race_rspv", 32'(rsp_valid), 32'b0001);
      chk("race_tmo", 32'(rsp_timeout), 0);
      chk("race_nack", 32'(rsp_nack), 1);
      ack = 1'b0;
      tick();

      // Reset while in WAIT_STOP, after rr_ptr has moved to 2
      set_req(1, 8'h50, 24'h0);
      req_valid = 4'b0010;
      wait_grant("mr_grant", 4'b0010, cyc);
      req_valid = '0;
      bus_start();
      rst = 1'b1;
      tick();
      chk_reset_outputs("mr");
      rst = 1'b0;
      scl = 1'b1;
      sda = 1'b1;
      tick();
      chk("mr_no_rsp", 32'(rsp_valid), 0);
      set_req(0, 8'h60, 24'h0);
      set_req(2, 8'h70, 24'h0);
      req_valid = 4'b0101;
      wait_grant("mr_ptr0", 4'b0001, cyc);
      req_valid = '0;

      // Contention from reset: all four held high
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      req_valid = 4'b1111;
      for (int unsigned i = 0; i < 5; i++) begin
         wait_grant("ct_grant", 4'(1 << (i % 4)), cyc);
         chk("ct_gap", cyc, (i == 0) ? 1 : 2);
         bus_start();
         bus_stop(1'b0, 24'h0);
         chk("ct_rspv", 32'(rsp_valid), 32'(1 << (i % 4)));
      end
      req_valid = '0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
